// File: rtl/if_fetch_stage.sv
// if_fetch_stage: in-order instruction fetch with slot-reserving prefetch queue and redirect flush
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0] fetch_pc, rsp_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] outstanding, discard_cnt;
  logic [31:0] instr_q [QDEPTH];
  logic [31:0] pc_q [QDEPTH];
  logic [CW:0] occ;
  logic rsp_fire, req_fire, push, pop;
  // Occupancy counts in-flight requests that will land in the queue, so responses always fit
  always_comb begin
    occ = (CW+1)'(count) + (CW+1)'(outstanding) - (CW+1)'(discard_cnt);
    rsp_fire = imem_rsp_valid && outstanding != '0;
    imem_req_valid = !reset && !redirect && outstanding < OW'(MAX_OUTSTANDING) && occ < (CW+1)'(QDEPTH);
    imem_req_addr = fetch_pc;
    req_fire = imem_req_valid && imem_req_ready;
    valid_out = count != '0 && !redirect;
    pop = valid_out && !stall;
    push = rsp_fire && !redirect && discard_cnt == '0;
    instruction_out = count != '0 ? instr_q[rd_ptr] : 32'h0;
    pc_out = count != '0 ? pc_q[rd_ptr] : 32'h0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rsp_pc <= {redirect_pc[31:2], 2'b00};
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        discard_cnt <= outstanding - OW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire && discard_cnt != '0) discard_cnt <= discard_cnt - OW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr] <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed tests of fetch stage with a behavioural imem (data = ~addr)
module tb_if_fetch_stage;
  logic clk = 0, reset = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0, instruction_out, pc_out;
  logic valid_out;
  logic w_req_valid, w_valid_out;
  logic [31:0] w_req_addr, w_instr, w_pc;
  int errors = 0, checks = 0, cyc = 0, lat = 1;
  logic [31:0] paddr[$];
  int pdue[$];

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .instruction_out(instruction_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0), .instruction_out(w_instr),
    .pc_out(w_pc), .valid_out(w_valid_out)
  );

  always #5 clk = ~clk;

  task automatic prep();
    if (paddr.size() != 0 && pdue[0] <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = ~paddr[0];
      void'(paddr.pop_front());
      void'(pdue.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
    end
    #1;
  endtask

  task automatic tick();
    if (imem_req_valid && imem_req_ready) begin
      paddr.push_back(imem_req_addr);
      pdue.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    reset = 1;
    stall = 0;
    redirect = 0;
    redirect_pc = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    imem_req_ready = 1;
    paddr.delete();
    pdue.delete();
    lat = l;
    repeat (2) @(negedge clk);
    reset = 0;
    cyc = 0;
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string name);
    logic found = 0;
    for (int i = 0; i < 14 && !found; i++) begin
      prep();
      if (valid_out) begin
        found = 1;
        checks++;
        if (pc_out !== exp_pc) begin errors++; $display("FAIL %s pc_out got %h exp %h", name, pc_out, exp_pc); end
        checks++;
        if (instruction_out !== ~exp_pc) begin errors++; $display("FAIL %s instr got %h exp %h", name, instruction_out, ~exp_pc); end
      end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL %s timeout got no valid_out exp pc %h", name, exp_pc); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid got %b exp 0", imem_req_valid); end
    checks++;
    if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset addr got %h exp 0", imem_req_addr); end
    checks++;
    if ({valid_out, pc_out, instruction_out} !== 65'h0) begin errors++; $display("FAIL reset outputs got %b %h %h exp 0", valid_out, pc_out, instruction_out); end
    checks++;
    if (w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset wrap_addr got %h exp fffffffc", w_req_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    for (int c = 0; c < 12; c++) begin
      prep();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
        errors++; $display("FAIL stream req c%0d got %b %h exp 1 %h", c, imem_req_valid, imem_req_addr, 32'(4 * c));
      end
      checks++;
      if (valid_out !== (c >= 2)) begin errors++; $display("FAIL stream valid c%0d got %b exp %b", c, valid_out, c >= 2); end
      if (c >= 2) begin
        checks++;
        if (pc_out !== 32'(4 * (c - 2)) || instruction_out !== ~32'(4 * (c - 2))) begin
          errors++; $display("FAIL stream data c%0d got %h %h exp %h", c, pc_out, instruction_out, 32'(4 * (c - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc = 0;
    do_reset(1);
    stall = 1;
    repeat (5) begin prep(); tick(); end
    prep();
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall req_valid got %b exp 0", imem_req_valid); end
    checks++;
    if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL stall addr got %h exp 10", imem_req_addr); end
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL stall head got %b %h exp 1 0", valid_out, pc_out); end
    tick();
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      prep();
      checks++;
      if (valid_out !== 1'b1 || pc_out !== exp_pc || instruction_out !== ~exp_pc) begin
        errors++; $display("FAIL stall_drain %0d got %b %h %h exp 1 %h", i, valid_out, pc_out, instruction_out, exp_pc);
      end
      exp_pc += 4;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(3);
    repeat (2) begin prep(); tick(); end
    redirect = 1;
    redirect_pc = 32'h100;
    prep();
    checks++;
    if (imem_req_valid !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL redir cycle got %b %b exp 0 0", imem_req_valid, valid_out); end
    tick();
    redirect = 0;
    prep();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir cap got %b %h exp 0 100", imem_req_valid, imem_req_addr); end
    tick();
    prep();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir refetch got %b %h exp 1 100", imem_req_valid, imem_req_addr); end
    tick();
    wait_valid(32'h100, "redir_first");
  endtask

  task automatic test_redirect_rsp();
    do_reset(2);
    stall = 1;
    repeat (5) begin prep(); tick(); end
    prep();
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL rr head got %b %h exp 1 0", valid_out, pc_out); end
    redirect = 1;
    redirect_pc = 32'h200;
    #1;
    checks++;
    if (valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rr cycle got %b %b exp 0 0", valid_out, imem_req_valid); end
    tick();
    redirect = 0;
    checks++;
    if (dut.discard_cnt !== 2'd1) begin errors++; $display("FAIL rr discard_cnt got %0d exp 1", dut.discard_cnt); end
    prep();
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rr flushed got %b exp 0", valid_out); end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rr refetch got %b %h exp 1 200", imem_req_valid, imem_req_addr); end
    tick();
    stall = 0;
    wait_valid(32'h200, "rr_first");
  endtask

  task automatic test_align_wrap();
    do_reset(1);
    redirect = 1;
    redirect_pc = 32'h203;
    prep();
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap start got %b %h exp 1 fffffffc", w_req_valid, w_req_addr); end
    tick();
    redirect = 0;
    prep();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL align got %b %h exp 1 200", imem_req_valid, imem_req_addr); end
    checks++;
    if (w_req_addr !== 32'h0) begin errors++; $display("FAIL wrap next got %h exp 0", w_req_addr); end
    tick();
    wait_valid(32'h200, "align_first");
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    stall = 1;
    repeat (4) begin prep(); tick(); end
    prep();
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL mid head got %b %h exp 1 0", valid_out, pc_out); end
    #1;
    reset = 1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin errors++; $display("FAIL mid outputs got %b %h %h exp 0", valid_out, pc_out, instruction_out); end
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid req got %b %h exp 0 0", imem_req_valid, imem_req_addr); end
    paddr.delete();
    pdue.delete();
    @(negedge clk);
    reset = 0;
    stall = 0;
    cyc = 0;
    wait_valid(32'h0, "mid_refetch");
    wait_valid(32'h4, "mid_second");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_align_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
